// File: rtl/alu_pkg.sv
// ============================================================================
// Module : alu_pkg
// Brief  : Command codes, status bit positions and FSM states for alu_seq.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

   localparam logic [3:0] CMD_MOV = 4'b0001;
   localparam logic [3:0] CMD_ADD = 4'b0010;
   localparam logic [3:0] CMD_ADC = 4'b0011;
   localparam logic [3:0] CMD_SUB = 4'b0100;
   localparam logic [3:0] CMD_SBC = 4'b0101;
   localparam logic [3:0] CMD_AND = 4'b0110;
   localparam logic [3:0] CMD_ORR = 4'b0111;
   localparam logic [3:0] CMD_EOR = 4'b1000;
   localparam logic [3:0] CMD_MVN = 4'b1001;
   localparam logic [3:0] CMD_MUL = 4'b1010;

   localparam int ST_N = 3;
   localparam int ST_Z = 2;
   localparam int ST_C = 1;
   localparam int ST_V = 0;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_MUL  = 1'b1
   } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_mul_iter.sv
// ============================================================================
// Module : alu_mul_iter
// Brief  : Radix-2 shift-add multiplier, one multiplier bit per clock edge.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_mul_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_mplier;
   logic [WIDTH-1:0] r_acc;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] w_addend;

   // product already includes the current bit, so on the done edge it is final
   assign w_addend = r_mplier[0] ? r_mcand : '0;
   assign product  = r_acc + w_addend;
   assign busy     = (r_cnt != '0);
   assign done     = (r_cnt == CW'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
      end else if (start) begin
         r_mcand  <= a;
         r_mplier <= b;
         r_acc    <= '0;
         r_cnt    <= CW'(WIDTH);
      end else if (busy) begin
         r_acc    <= product;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt - CW'(1);
      end
   end

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// ============================================================================
// Module : alu_seq
// Brief  : Registered EXE-stage ALU with NZCV status, valid/ready handshake
//          and an optional iterative multiplier.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_seq #(
   parameter int WIDTH  = 32,
   parameter bit MUL_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             carry,
   input  logic [3:0]       command,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic [3:0]       status
);

   import alu_pkg::*;

   state_t           r_state;
   logic             w_accept;
   logic             w_is_mul;
   logic             w_is_sub;
   logic             w_is_arith;
   logic [WIDTH-1:0] w_b;
   logic             w_cin;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH-1:0] w_res;
   logic [3:0]       w_st;
   logic [3:0]       w_mul_st;
   logic             w_mul_busy;
   logic             w_mul_done;
   logic [WIDTH-1:0] w_mul_prod;

   // rst_n gates ready so nothing is offered while the block is held in reset
   assign in_ready = rst_n && (r_state == S_IDLE) && !w_mul_busy && (!out_valid || out_ready);
   assign w_accept = in_valid && in_ready;
   assign w_is_mul = MUL_EN && (command == CMD_MUL);

   always_comb begin
      w_is_sub   = (command == CMD_SUB) || (command == CMD_SBC);
      w_is_arith = w_is_sub || (command == CMD_ADD) || (command == CMD_ADC);
      w_b        = w_is_sub ? ~in2 : in2;
      if (command == CMD_SUB)
         w_cin = 1'b1;
      else if ((command == CMD_ADC) || (command == CMD_SBC))
         w_cin = carry;
      else
         w_cin = 1'b0;
      w_sum = {1'b0, in1} + {1'b0, w_b} + {{WIDTH{1'b0}}, w_cin};

      case (command)
         CMD_MOV: w_res = in2;
         CMD_MVN: w_res = ~in2;
         CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: w_res = w_sum[WIDTH-1:0];
         CMD_AND: w_res = in1 & in2;
         CMD_ORR: w_res = in1 | in2;
         CMD_EOR: w_res = in1 ^ in2;
         default: w_res = '0;
      endcase

      w_st       = 4'b0000;
      w_st[ST_N] = w_res[WIDTH-1];
      w_st[ST_Z] = (w_res == '0);
      w_st[ST_C] = w_is_arith && w_sum[WIDTH];
      // w_b is already inverted for subtracts, so one overflow rule covers both
      w_st[ST_V] = w_is_arith && (in1[WIDTH-1] == w_b[WIDTH-1])
                              && (w_res[WIDTH-1] != in1[WIDTH-1]);

      w_mul_st       = 4'b0000;
      w_mul_st[ST_N] = w_mul_prod[WIDTH-1];
      w_mul_st[ST_Z] = (w_mul_prod == '0);
   end

   alu_mul_iter #(
      .WIDTH (WIDTH)
   ) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (w_accept && w_is_mul),
      .a       (in1),
      .b       (in2),
      .busy    (w_mul_busy),
      .done    (w_mul_done),
      .product (w_mul_prod)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         out_valid <= 1'b0;
         out       <= '0;
         status    <= 4'b0000;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept && w_is_mul) begin
                  r_state   <= S_MUL;
                  out_valid <= 1'b0;
               end else if (w_accept) begin
                  out       <= w_res;
                  status    <= w_st;
                  out_valid <= 1'b1;
               end else if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
               end
            end
            S_MUL: begin
               if (w_mul_done) begin
                  out       <= w_mul_prod;
                  status    <= w_mul_st;
                  out_valid <= 1'b1;
                  r_state   <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// ============================================================================
// Module : tb_alu_seq
// Brief  : Self-checking bench for alu_seq (vector table, corner sequences,
//          randomized ops against an arithmetic reference model).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, carry, out_valid, out_ready;
   logic [31:0] in1, in2, out;
   logic [3:0]  command, status;

   logic        d2_in_valid, d2_in_ready, d2_out_valid, d2_out_ready;
   logic [31:0] d2_out;
   logic [3:0]  d2_status;

   int npass = 0;
   int ntot  = 0;

   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483648;

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(32), .MUL_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in1(in1), .in2(in2), .carry(carry), .command(command),
      .out_valid(out_valid), .out_ready(out_ready), .out(out), .status(status)
   );

   alu_seq #(.WIDTH(32), .MUL_EN(1'b0)) dut_nomul (
      .clk(clk), .rst_n(rst_n), .in_valid(d2_in_valid), .in_ready(d2_in_ready),
      .in1(in1), .in2(in2), .carry(carry), .command(command),
      .out_valid(d2_out_valid), .out_ready(d2_out_ready), .out(d2_out), .status(d2_status)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      ntot++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference: plain 64-bit arithmetic on unsigned and sign-extended operands
   function automatic logic [35:0] model(input logic [3:0] cmd, input logic [31:0] a,
                                         input logic [31:0] b, input logic c, input bit mul_en);
      longint ua, ub, sa, sb, u, s, bw;
      logic [31:0] r;
      bit cf, vf;
      ua = {32'b0, a};
      ub = {32'b0, b};
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      r = 32'd0; cf = 0; vf = 0;
      case (cmd)
         4'b0001: r = b;
         4'b1001: r = ~b;
         4'b0010, 4'b0011: begin
            bw = (cmd == 4'b0011 && c) ? 64'd1 : 64'd0;
            u = ua + ub + bw;
            s = sa + sb + bw;
            r = u[31:0];
            cf = (u > 64'sd4294967295);
            vf = (s > SMAX) || (s < SMIN);
         end
         4'b0100, 4'b0101: begin
            bw = (cmd == 4'b0101 && !c) ? 64'd1 : 64'd0;
            u = ua - ub - bw;
            s = sa - sb - bw;
            r = u[31:0];
            cf = (ua >= ub + bw);
            vf = (s > SMAX) || (s < SMIN);
         end
         4'b0110: r = a & b;
         4'b0111: r = a | b;
         4'b1000: r = a ^ b;
         4'b1010: if (mul_en) begin u = ua * ub; r = u[31:0]; end
         default: r = 32'd0;
      endcase
      return {r, r[31], (r == 32'd0), cf, vf};
   endfunction

   // Issue one op on dut; edges = clock edges after the accept edge until out_valid
   task automatic run_op(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                         input logic c, output logic [31:0] o, output logic [3:0] st,
                         output int edges, output bit rdy_seen);
      int w;
      @(negedge clk);
      command = cmd; in1 = a; in2 = b; carry = c; in_valid = 1'b1;
      w = 0;
      while (!in_ready && w < 100) begin @(negedge clk); w++; end
      if (!in_ready) chk("accept_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in1 = $urandom; in2 = $urandom; command = 4'($urandom); carry = 1'($urandom);
      edges = 0; rdy_seen = 0;
      while (!out_valid && edges < 100) begin
         if (in_ready) rdy_seen = 1;
         @(posedge clk); #1;
         edges++;
      end
      o = out; st = status;
   endtask

   typedef struct {
      logic [3:0]  cmd;
      logic [31:0] a, b;
      logic        c;
      logic [31:0] eo;
      logic [3:0]  es;
      int          eedges;
   } vec_t;

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h7FFFFFFF;
         1: return 32'h80000000;
         2: return 32'hFFFFFFFF;
         3: return 32'd0;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      vec_t        tbl[8];
      logic [31:0] o, a, b;
      logic [3:0]  st, cmd;
      logic        c;
      logic [35:0] exp;
      int          edges;
      bit          rdy_seen, stale;

      tbl[0] = '{4'b0010, 32'h7FFFFFFF, 32'd1, 1'b0, 32'h80000000, 4'b1001, 0};
      tbl[1] = '{4'b0100, 32'd5, 32'd5, 1'b0, 32'd0, 4'b0110, 0};
      tbl[2] = '{4'b0100, 32'd3, 32'd5, 1'b0, 32'hFFFFFFFE, 4'b1000, 0};
      tbl[3] = '{4'b0011, 32'hFFFFFFFF, 32'd0, 1'b1, 32'd0, 4'b0110, 0};
      tbl[4] = '{4'b0101, 32'd10, 32'd3, 1'b0, 32'd6, 4'b0010, 0};
      tbl[5] = '{4'b1010, 32'd7, 32'd6, 1'b0, 32'd42, 4'b0000, 32};
      tbl[6] = '{4'b1001, 32'd0, 32'd0, 1'b0, 32'hFFFFFFFF, 4'b1000, 0};
      tbl[7] = '{4'b1111, 32'd9, 32'd9, 1'b1, 32'd0, 4'b0100, 0};

      rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      in1 = 32'd1; in2 = 32'd2; carry = 1'b0; command = 4'b0010;
      d2_in_valid = 1'b0; d2_out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_in_ready", {63'd0, in_ready}, 64'd0);
      chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
      chk("reset_out", {32'd0, out}, 64'd0);
      chk("reset_status", {60'd0, status}, 64'd0);
      in_valid = 1'b0;
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         run_op(tbl[i].cmd, tbl[i].a, tbl[i].b, tbl[i].c, o, st, edges, rdy_seen);
         chk($sformatf("vec%0d_out", i), {32'd0, o}, {32'd0, tbl[i].eo});
         chk($sformatf("vec%0d_status", i), {60'd0, st}, {60'd0, tbl[i].es});
         chk($sformatf("vec%0d_latency", i), 64'(edges), 64'(tbl[i].eedges));
         chk($sformatf("vec%0d_busy_ready", i), {63'd0, rdy_seen}, 64'd0);
      end

      // MUL code is undefined when the multiplier is disabled
      @(negedge clk);
      command = 4'b1010; in1 = 32'd7; in2 = 32'd6; d2_in_valid = 1'b1;
      chk("nomul_in_ready", {63'd0, d2_in_ready}, 64'd1);
      @(posedge clk); #1;
      d2_in_valid = 1'b0;
      chk("nomul_result", {27'd0, d2_out_valid, d2_status, d2_out}, {27'd0, 1'b1, 4'b0100, 32'd0});

      // Backpressure: result must hold while out_ready is low
      @(negedge clk); out_ready = 1'b0;
      run_op(4'b0010, 32'd3, 32'd4, 1'b0, o, st, edges, rdy_seen);
      @(negedge clk);
      command = 4'b1000; in1 = 32'hF0; in2 = 32'hFF; in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         chk($sformatf("hold%0d", k), {26'd0, out_valid, in_ready, status, out},
             {26'd0, 1'b1, 1'b0, 4'b0000, 32'd7});
      end
      @(negedge clk); out_ready = 1'b1; #1;
      chk("release_in_ready", {63'd0, in_ready}, 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("release_new_result", {27'd0, out_valid, status, out}, {27'd0, 1'b1, 4'b0000, 32'h0F});

      for (int n = 0; n < 150; n++) begin
         cmd = 4'($urandom); a = pick(); b = pick(); c = 1'($urandom);
         if (n % 6 == 0) cmd = 4'b1010;
         exp = model(cmd, a, b, c, 1'b1);
         run_op(cmd, a, b, c, o, st, edges, rdy_seen);
         chk($sformatf("rand%0d_cmd%0h_out", n, cmd), {32'd0, o}, {32'd0, exp[35:4]});
         chk($sformatf("rand%0d_cmd%0h_status", n, cmd), {60'd0, st}, {60'd0, exp[3:0]});
      end

      // Reset in the middle of a multiply
      run_op(4'b0100, 32'd3, 32'd5, 1'b0, o, st, edges, rdy_seen);
      chk("pre_reset_status", {60'd0, st}, {60'd0, 4'b1000});
      @(negedge clk);
      command = 4'b1010; in1 = 32'd7; in2 = 32'd6; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0; #1;
      chk("midmul_reset", {26'd0, out_valid, in_ready, status, out}, 64'd0);
      @(negedge clk); rst_n = 1'b1;
      stale = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (out_valid) stale = 1;
      end
      chk("no_stale_result", {63'd0, stale}, 64'd0);
      chk("post_reset_in_ready", {63'd0, in_ready}, 64'd1);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule

`default_nettype wire
